button_debounce: RTL and testbench

Push-button input conditioner for the board-level I/O path: the input-side counterpart to the LED-driving counters. It synchronises a raw, bouncing, active-low push-button into the CLK50 domain and filters it with a cycle-counted debounce window. It emits a clean level, one-cycle press/release/long-press pulses and a running press count for downstream logic (mode selection, LED pattern stepping).

---
 rtl/button_debounce_if.sv | 22 ++
 rtl/button_debounce.sv | 149 ++++++++++++++
 tb/tb_button_debounce.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Push-button conditioner port bundle: raw active-low button in, clean level,
// one-cycle event pulses and a running press count out.
interface button_debounce_if;
    logic       BTN_N;
    logic       BTN_LEVEL;
    logic       PRESS_PULSE;
    logic       RELEASE_PULSE;
    logic       LONG_PULSE;
    logic [7:0] PRESS_COUNT;

    // Driver of the raw button / consumer of the conditioned outputs
    modport master (
        output BTN_N,
        input  BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, PRESS_COUNT
    );

    // The debouncer itself
    modport slave (
        input  BTN_N,
        output BTN_LEVEL, PRESS_PULSE, RELEASE_PULSE, LONG_PULSE, PRESS_COUNT
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises the raw active-low button into the
// CLK50 domain, accepts a press or release only after the synchronised level
// has been stable for DEBOUNCE_CYCLES, and emits a clean level, one-cycle
// press/release/long-press pulses and a wrapping 8-bit press count.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             CLK50,
    input  logic             RST,
    button_debounce_if.slave btn
);

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t      state_q, state_d;
    logic [31:0] dcnt_q, dcnt_d;
    logic [31:0] hcnt_q, hcnt_d;
    logic        long_done_q, long_done_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic [7:0]  count_q, count_d;

    // Synchroniser: shift the inverted (active-high) button through the chain
    always_ff @(posedge CLK50 or negedge RST) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ~btn.BTN_N};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counters and registered outputs
    always_ff @(posedge CLK50 or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    // Next-state logic: debounce windows, hold timing and event pulses
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        count_d     = count_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 32'd1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    // hcnt is frozen while a possible release is being qualified
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end else if (!long_done_q) begin
                    if (hcnt_q == LONG_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + 32'd1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    // Bounce while held: resume the same press, no new event
                    state_d = PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign btn.BTN_LEVEL     = level_q;
    assign btn.PRESS_PULSE   = press_q;
    assign btn.RELEASE_PULSE = release_q;
    assign btn.LONG_PULSE    = long_q;
    assign btn.PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios with hand-computed cycle
// expectations, then randomized button activity, all compared every cycle
// against a run-length reference model of the debounce rules.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 16;
    localparam int S = 2;

    logic CLK50 = 1'b0;
    logic RST   = 1'b0;

    button_debounce_if bif ();

    button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .SYNC_STAGES    (S)
    ) dut (
        .CLK50(CLK50),
        .RST  (RST),
        .btn  (bif)
    );

    always #5 CLK50 = ~CLK50;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    int n_press = 0;
    int n_rel   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A press (release) is accepted once the synchronised
    // sample has differed from the accepted level for D+1 consecutive
    // samples. Hold time advances on each sample that is the second or
    // later of a run of 'pressed' samples while the level is pressed.
    // ------------------------------------------------------------------
    bit         hist [S];
    bit         m_prev_s;
    int         m_run;
    int         m_hold;
    bit         m_fired;
    bit         exp_level, exp_press, exp_rel, exp_long;
    logic [7:0] exp_count = '0;

    always @(posedge CLK50 or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < S; i++) hist[i] = 1'b0;
            m_prev_s  = 1'b0;
            m_run     = 0;
            m_hold    = 0;
            m_fired   = 1'b0;
            exp_level = 1'b0;
            exp_press = 1'b0;
            exp_rel   = 1'b0;
            exp_long  = 1'b0;
            exp_count = '0;
        end else begin
            bit s, prev;
            s    = hist[S-1];
            prev = m_prev_s;
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ~bif.BTN_N;
            m_run    = (s == prev) ? m_run + 1 : 1;
            m_prev_s = s;

            exp_press = 1'b0;
            exp_rel   = 1'b0;
            exp_long  = 1'b0;

            if (exp_level && prev && s && !m_fired) begin
                m_hold++;
                if (m_hold == L) begin
                    exp_long = 1'b1;
                    m_fired  = 1'b1;
                end
            end

            if (s != exp_level && m_run == D + 1) begin
                if (s) begin
                    exp_level = 1'b1;
                    exp_press = 1'b1;
                    exp_count = exp_count + 8'd1;
                    m_hold    = 0;
                    m_fired   = 1'b0;
                end else begin
                    exp_level = 1'b0;
                    exp_rel   = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge CLK50) begin
        if (cmp_en) begin
            check("model.level",   32'(bif.BTN_LEVEL),     32'(exp_level));
            check("model.press",   32'(bif.PRESS_PULSE),   32'(exp_press));
            check("model.release", 32'(bif.RELEASE_PULSE), 32'(exp_rel));
            check("model.long",    32'(bif.LONG_PULSE),    32'(exp_long));
            check("model.count",   32'(bif.PRESS_COUNT),   32'(exp_count));
        end
    end

    // Advance to the middle of the next cycle and tally pulses
    task automatic step();
        @(negedge CLK50);
        #1;
        if (bif.PRESS_PULSE === 1'b1)   n_press++;
        if (bif.RELEASE_PULSE === 1'b1) n_rel++;
    endtask

    task automatic check_cycle(input string tag, input int k, input int p_at,
                               input int r_at, input int l_at, input bit lvl);
        check({tag, ".press"},   32'(bif.PRESS_PULSE),   32'(k == p_at));
        check({tag, ".release"}, 32'(bif.RELEASE_PULSE), 32'(k == r_at));
        check({tag, ".long"},    32'(bif.LONG_PULSE),    32'(k == l_at));
        check({tag, ".level"},   32'(bif.BTN_LEVEL),     32'(lvl));
    endtask

    initial begin
        int p0, r0;

        bif.BTN_N = 1'b1;
        RST       = 1'b0;
        repeat (3) step();
        check("reset.level", 32'(bif.BTN_LEVEL),   32'd0);
        check("reset.count", 32'(bif.PRESS_COUNT), 32'd0);
        RST    = 1'b1;
        cmp_en = 1'b1;
        repeat (5) step();

        // Clean press then release
        bif.BTN_N = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            check_cycle("clean", k, 7, 17, -1, (k >= 7 && k < 17));
            if (k == 10) bif.BTN_N = 1'b1;
        end
        check("clean.count", 32'(bif.PRESS_COUNT), 32'd1);

        // Bounce on press, then a 3-cycle release glitch while held
        p0 = n_press;
        r0 = n_rel;
        bif.BTN_N = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            check("bounce.press",   32'(bif.PRESS_PULSE),   32'(k == 27));
            check("bounce.release", 32'(bif.RELEASE_PULSE), 32'd0);
            check("bounce.level",   32'(bif.BTN_LEVEL),     32'(k >= 27));
            if (k < 20 && k % 2 == 0) bif.BTN_N = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            if (k == 20) bif.BTN_N = 1'b0;
            if (k == 41) bif.BTN_N = 1'b1;
            if (k == 44) bif.BTN_N = 1'b0;
        end
        check("bounce.npress", 32'(n_press - p0), 32'd1);
        check("bounce.nrel",   32'(n_rel - r0),   32'd0);
        check("bounce.count",  32'(bif.PRESS_COUNT), 32'd2);
        bif.BTN_N = 1'b1;
        repeat (15) step();

        // Long press
        bif.BTN_N = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_cycle("long", k, 7, 47, 23, (k >= 7 && k < 47));
            if (k == 40) bif.BTN_N = 1'b1;
        end

        // Long press across a 3-cycle glitch: long delayed by 4 frozen cycles
        bif.BTN_N = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_cycle("longglitch", k, 7, 47, 27, (k >= 7 && k < 47));
            if (k == 12) bif.BTN_N = 1'b1;
            if (k == 15) bif.BTN_N = 1'b0;
            if (k == 40) bif.BTN_N = 1'b1;
        end
        repeat (5) step();

        // Asynchronous reset mid-press, released with the button still held
        bif.BTN_N = 1'b0;
        repeat (10) step();
        RST = 1'b0;
        #1;
        check("rstmid.level",   32'(bif.BTN_LEVEL),     32'd0);
        check("rstmid.press",   32'(bif.PRESS_PULSE),   32'd0);
        check("rstmid.release", 32'(bif.RELEASE_PULSE), 32'd0);
        check("rstmid.long",    32'(bif.LONG_PULSE),    32'd0);
        check("rstmid.count",   32'(bif.PRESS_COUNT),   32'd0);
        step();
        step();
        RST = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_cycle("rstrel", k, 7, -1, -1, (k >= 7));
            if (k == 7) check("rstrel.count", 32'(bif.PRESS_COUNT), 32'd1);
        end
        bif.BTN_N = 1'b1;
        repeat (15) step();

        // Press counter wrap: 257 clean presses from a fresh reset
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
        p0 = n_press;
        r0 = n_rel;
        for (int i = 0; i < 257; i++) begin
            bif.BTN_N = 1'b0;
            repeat (8) step();
            bif.BTN_N = 1'b1;
            repeat (8) step();
        end
        check("wrap.npress", 32'(n_press - p0),     32'd257);
        check("wrap.nrel",   32'(n_rel - r0),       32'd257);
        check("wrap.count",  32'(bif.PRESS_COUNT),  32'd1);

        // Randomized button activity with occasional resets
        for (int r = 0; r < 250; r++) begin
            int len;
            len       = $urandom_range(1, 30);
            bif.BTN_N = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b0;
                step();
                step();
                RST = 1'b1;
            end
            repeat (len) step();
        end
        bif.BTN_N = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
